// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that grants one of NUM_REQ requesters ownership of a
// downstream fifo write port for a burst of up to MAX_BURST words. Bursts
// end on the MAX_BURST-th transfer or when the owner runs dry, and every
// burst is followed by one IDLE cycle in which the next owner is chosen.

module fifo_write_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int BITS_PER_ELEMENT = 32,
  parameter int MAX_BURST        = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ*BITS_PER_ELEMENT-1:0] i_req_data,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic                                o_fifo_write,
  output logic [BITS_PER_ELEMENT-1:0]         o_fifo_data,
  input  logic                                i_fifo_full,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic                                o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             r_state;
  state_t             next_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_count;

  logic [IDX_W-1:0]   pick_idx;
  logic               any_valid;
  logic               owner_valid;
  logic               xfer;
  logic               last_xfer;
  logic               burst_end;
  int                 cand;

  // Valid bit of the current owner, selected by compare so the index never
  // reaches past NUM_REQ when NUM_REQ is not a power of two.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    owner_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == IDX_W'(k)) owner_valid = i_req_valid[k];
    end
  end

  // Round-robin pick: first valid requester at r_last+1, r_last+2, ... with
  // wrap at NUM_REQ. Offsets are scanned farthest-first so the nearest
  // valid candidate is the last one written and therefore wins.
  always_comb begin
    any_valid = 1'b0;
    pick_idx  = '0;
    cand      = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(r_last) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == cand && i_req_valid[k]) begin
          pick_idx  = IDX_W'(k);
          any_valid = 1'b1;
        end
      end
    end
  end

  // Burst bookkeeping: a transfer needs the owner valid and room in the fifo;
  // a full-stall cycle is neither a transfer nor a burst end.
  always_comb begin
    xfer      = (r_state == S_BURST) && owner_valid && !i_fifo_full;
    last_xfer = xfer && (r_count == CNT_W'(MAX_BURST - 1));
    burst_end = (r_state == S_BURST) && (!owner_valid || last_xfer);
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (any_valid) next_state = S_BURST;
      S_BURST: if (burst_end) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Owner, last-served index and burst counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= '0;
      r_count <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (any_valid) begin
            r_owner <= pick_idx;
            r_count <= '0;
          end
        end
        S_BURST: begin
          if (burst_end) r_last <= r_owner;
          if (xfer)      r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs: all zero in IDLE; in BURST only the owner is granted and its
  // data is steered combinationally to the fifo.
  always_comb begin
    o_grant      = '0;
    o_req_ready  = '0;
    o_fifo_write = 1'b0;
    o_fifo_data  = '0;
    o_busy       = 1'b0;
    if (r_state == S_BURST) begin
      o_busy       = 1'b1;
      o_fifo_write = xfer;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (r_owner == IDX_W'(k)) begin
          o_grant[k]     = 1'b1;
          o_req_ready[k] = !i_fifo_full;
          o_fifo_data    = i_req_data[k*BITS_PER_ELEMENT +: BITS_PER_ELEMENT];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: a 4-requester instance driven by a
// counting requester model with a word scoreboard, and a 3-requester
// instance used to exercise index wrap with non-power-of-two NUM_REQ.

module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [NR-1:0]   i_req_valid;
  logic [NR*W-1:0] i_req_data;
  logic [NR-1:0]   o_req_ready;
  logic            o_fifo_write;
  logic [W-1:0]    o_fifo_data;
  logic            i_fifo_full;
  logic [NR-1:0]   o_grant;
  logic            o_busy;

  logic            rst3;
  logic [2:0]      valid3;
  logic [3*W-1:0]  data3;
  logic [2:0]      ready3;
  logic            write3;
  logic [W-1:0]    fdata3;
  logic            full3;
  logic [2:0]      grant3;
  logic            busy3;

  int              checks = 0;
  int              errors = 0;
  logic [W-1:0]    exp_q[$];
  int              seq[NR];
  logic [NR-1:0]   fire = '0;

  always #5 i_clk = ~i_clk;

  fifo_write_arbiter #(.NUM_REQ(NR), .BITS_PER_ELEMENT(W), .MAX_BURST(MB)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_fifo_write(o_fifo_write),
    .o_fifo_data (o_fifo_data),
    .i_fifo_full (i_fifo_full),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .BITS_PER_ELEMENT(W), .MAX_BURST(MB)) dut3 (
    .i_clk       (i_clk),
    .i_rst       (rst3),
    .i_req_valid (valid3),
    .i_req_data  (data3),
    .o_req_ready (ready3),
    .o_fifo_write(write3),
    .o_fifo_data (fdata3),
    .i_fifo_full (full3),
    .o_grant     (grant3),
    .o_busy      (busy3)
  );

  // Word k of requester r carries its index in the top byte and a running
  // sequence number below, so lost, duplicated or misrouted words show up.
  function automatic logic [W-1:0] word_of(input int r, input int s);
    return {8'hA0 + 8'(r), 24'(s)};
  endfunction

  task automatic refresh_data();
    for (int k = 0; k < NR; k++) i_req_data[k*W +: W] = word_of(k, seq[k]);
  endtask

  // Advance one clock: requesters whose word was accepted at this edge move
  // on to their next word, then inputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NR; k++) if (fire[k]) seq[k]++;
    refresh_data();
  endtask

  // Scoreboard monitor: every fifo write must be the next expected word,
  // and both grant vectors must be one-hot or zero every cycle.
  always @(negedge i_clk) begin
    fire = i_req_valid & o_req_ready;
    checks++;
    if (!$onehot0(o_grant)) begin
      errors++;
      $display("FAIL grant_onehot: got %b required one-hot or zero", o_grant);
    end
    checks++;
    if (!$onehot0(grant3)) begin
      errors++;
      $display("FAIL grant3_onehot: got %b required one-hot or zero", grant3);
    end
    if (o_fifo_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_unexpected_write: got data %h required no write", o_fifo_data);
      end else begin
        logic [W-1:0] exp_w;
        exp_w = exp_q.pop_front();
        if (o_fifo_data !== exp_w) begin
          errors++;
          $display("FAIL fifo_data: got %h required %h", o_fifo_data, exp_w);
        end
      end
    end
  end

  task automatic test_reset();
    logic [2*NR+1:0] obs;
    i_rst       = 1'b1;
    i_req_valid = '1;
    tick();
    tick();
    @(negedge i_clk);
    obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
    checks++;
    if (obs !== '0 || o_fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_held: got ctl %b data %h required all zero", obs, o_fifo_data);
    end
    tick();
    i_rst       = 1'b0;
    i_req_valid = '0;
    @(negedge i_clk);
    obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
    checks++;
    if (obs !== '0 || o_fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_after: got ctl %b data %h required all zero", obs, o_fifo_data);
    end
  endtask

  // All four valid with room in the fifo: bursts of MB words in order
  // 0,1,2,3,0 separated by exactly one IDLE cycle.
  task automatic test_round_robin();
    int              order[5] = '{0, 1, 2, 3, 0};
    int              base[NR];
    logic [NR-1:0]   g;
    logic            b;
    logic [2*NR+1:0] obs;
    for (int k = 0; k < NR; k++) base[k] = seq[k];
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < MB; i++) exp_q.push_back(word_of(order[n], base[order[n]] + i));
      base[order[n]] += MB;
    end
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c == 0) i_req_valid = '1;
      @(negedge i_clk);
      b   = (c % 5) != 0;
      g   = b ? (NR'(1) << order[c / 5]) : '0;
      obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
      checks++;
      if (obs !== {g, g, b, b}) begin
        errors++;
        $display("FAIL rr_c%0d: got %b required %b", c, obs, {g, g, b, b});
      end
    end
    tick();
    i_req_valid = '0;
    @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_end: got %0d words pending busy %b required 0 and 0", exp_q.size(), o_busy);
    end
  endtask

  // Requester 2 alone for two words, then drops; r_last=2 makes the next
  // arbitration over 4'b0101 pick requester 0.
  task automatic test_drop();
    logic [NR-1:0]   vld[10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0101,
                                 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
    logic [2*NR+1:0] exp_t[10] = '{10'b0000_0000_00, 10'b0100_0100_11, 10'b0100_0100_11,
                                   10'b0100_0100_01, 10'b0000_0000_00, 10'b0001_0001_11,
                                   10'b0001_0001_11, 10'b0001_0001_11, 10'b0001_0001_11,
                                   10'b0000_0000_00};
    logic [2*NR+1:0] obs;
    exp_q.push_back(word_of(2, seq[2]));
    exp_q.push_back(word_of(2, seq[2] + 1));
    for (int i = 0; i < MB; i++) exp_q.push_back(word_of(0, seq[0] + i));
    for (int c = 0; c < 10; c++) begin
      tick();
      i_req_valid = vld[c];
      @(negedge i_clk);
      obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL drop_c%0d: got %b required %b", c, obs, exp_t[c]);
      end
      if (exp_t[c] == '0) begin
        checks++;
        if (o_fifo_data !== '0) begin
          errors++;
          $display("FAIL drop_idle_data_c%0d: got %h required 0", c, o_fifo_data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_end: got %0d words pending required 0", exp_q.size());
    end
  endtask

  // Requester 1 owns; fifo full for three cycles after two words. The stall
  // must block ready and write, keep the count, and the burst still ends
  // after exactly MB words.
  task automatic test_stall();
    logic            full_t[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [2*NR+1:0] exp_t[9] = '{10'b0000_0000_00, 10'b0010_0010_11, 10'b0010_0010_11,
                                  10'b0010_0000_01, 10'b0010_0000_01, 10'b0010_0000_01,
                                  10'b0010_0010_11, 10'b0010_0010_11, 10'b0000_0000_00};
    logic [2*NR+1:0] obs;
    for (int i = 0; i < MB; i++) exp_q.push_back(word_of(1, seq[1] + i));
    for (int c = 0; c < 9; c++) begin
      tick();
      i_req_valid = (c < 8) ? 4'b0010 : 4'b0000;
      i_fifo_full = full_t[c];
      @(negedge i_clk);
      obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL stall_c%0d: got %b required %b", c, obs, exp_t[c]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: got %0d words pending required 0", exp_q.size());
    end
  endtask

  // Reset during the second word of a requester-1 burst: that word is still
  // written, the next cycle is IDLE with zero outputs, and requester 0 wins.
  task automatic test_reset_mid();
    logic [NR-1:0]   vld[7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    logic [2*NR+1:0] exp_t[7] = '{10'b0000_0000_00, 10'b0010_0010_11, 10'b0010_0010_11,
                                  10'b0000_0000_00, 10'b0001_0001_11, 10'b0001_0001_01,
                                  10'b0000_0000_00};
    logic [2*NR+1:0] obs;
    exp_q.push_back(word_of(1, seq[1]));
    exp_q.push_back(word_of(1, seq[1] + 1));
    exp_q.push_back(word_of(0, seq[0]));
    for (int c = 0; c < 7; c++) begin
      tick();
      i_req_valid = vld[c];
      i_rst       = (c == 2);
      @(negedge i_clk);
      obs = {o_grant, o_req_ready, o_fifo_write, o_busy};
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL rstmid_c%0d: got %b required %b", c, obs, exp_t[c]);
      end
      if (exp_t[c] == '0) begin
        checks++;
        if (o_fifo_data !== '0) begin
          errors++;
          $display("FAIL rstmid_idle_data_c%0d: got %h required 0", c, o_fifo_data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_end: got %0d words pending required 0", exp_q.size());
    end
  endtask

  // NUM_REQ=3 with all valid from reset: owners 0,1,2,0 with wrap at 3.
  task automatic test_wrap();
    logic [2:0]   g;
    logic         b;
    logic [W-1:0] d;
    logic [7:0]   obs;
    tick();
    rst3 = 1'b0;
    for (int c = 0; c < 21; c++) begin
      @(negedge i_clk);
      b   = (c % 5) != 0;
      g   = b ? (3'(1) << ((c / 5) % 3)) : '0;
      d   = b ? word_of((c / 5) % 3, 99) : '0;
      obs = {grant3, ready3, write3, busy3};
      checks++;
      if (obs !== {g, g, b, b} || fdata3 !== d) begin
        errors++;
        $display("FAIL wrap_c%0d: got ctl %b data %h required ctl %b data %h",
                 c, obs, fdata3, {g, g, b, b}, d);
      end
      tick();
    end
    valid3 = '0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_fifo_full = 1'b0;
    for (int k = 0; k < NR; k++) seq[k] = 0;
    refresh_data();
    rst3   = 1'b1;
    full3  = 1'b0;
    valid3 = 3'b111;
    for (int k = 0; k < 3; k++) data3[k*W +: W] = word_of(k, 99);

    test_reset();
    test_round_robin();
    test_drop();
    test_stall();
    test_reset_mid();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
